// File: rtl/dac_carry_scan.sv
// Offset-sweep sequencer for the stepped DAC test-waveform generator: settle, dwell, advance per point.
// Optional continuous looping of the sweep is enabled by defining DAC_SCAN_LOOP_EN.
module dac_carry_scan #(
  parameter int unsigned SETTLE       = 16,
  parameter int unsigned PERIOD_TICKS = 60,
  parameter int unsigned REPW         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        N_in,
  input  logic signed [15:0] step_in,
  input  logic signed [15:0] off_start,
  input  logic signed [15:0] off_stop,
  input  logic signed [15:0] off_inc,
  input  logic [REPW-1:0]    reps,
  output logic [31:0]        N_out,
  output logic signed [15:0] step_out,
  output logic signed [15:0] offset_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               sync,
  output logic [15:0]        point_idx
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_DWELL, S_ADV, S_DONE} state_t;

  state_t             state;
  logic signed [15:0] step_l;
  logic signed [15:0] stop_l;
  logic signed [15:0] inc_l;
`ifdef DAC_SCAN_LOOP_EN
  logic signed [15:0] start_l;
`endif
  logic [31:0]        ticks_total;
  logic [31:0]        clk_cnt;
  logic [31:0]        tick_cnt;
  logic [15:0]        settle_cnt;

  logic [REPW-1:0]    reps_eff_c;
  logic signed [16:0] nxt_c;
  logic signed [16:0] stop_ext_c;
  logic               last_c;

  // Next offset in 17 bits so that leaving the 16-bit range ends the sweep rather than wrapping.
  always_comb begin
    reps_eff_c = (reps == '0) ? REPW'(1) : reps;
    nxt_c      = {offset_out[15], offset_out} + {inc_l[15], inc_l};
    stop_ext_c = {stop_l[15], stop_l};
    last_c     = 1'b0;
    if (inc_l == 16'sd0)                      last_c = 1'b1;
    if (!inc_l[15] && (nxt_c > stop_ext_c))   last_c = 1'b1;
    if (inc_l[15] && (nxt_c < stop_ext_c))    last_c = 1'b1;
    if (nxt_c[16] != nxt_c[15])               last_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      step_l      <= '0;
      stop_l      <= '0;
      inc_l       <= '0;
`ifdef DAC_SCAN_LOOP_EN
      start_l     <= '0;
`endif
      ticks_total <= '0;
      clk_cnt     <= '0;
      tick_cnt    <= '0;
      settle_cnt  <= '0;
      N_out       <= 32'd1;
      step_out    <= '0;
      offset_out  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sync        <= 1'b0;
      point_idx   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      sync <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state    <= S_IDLE;
        step_out <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              if (N_in == 32'd0) begin
                err <= 1'b1;
              end else begin
                N_out       <= N_in;
                step_l      <= step_in;
                stop_l      <= off_stop;
                inc_l       <= off_inc;
`ifdef DAC_SCAN_LOOP_EN
                start_l     <= off_start;
`endif
                ticks_total <= 32'(reps_eff_c) * 32'(PERIOD_TICKS);
                offset_out  <= off_start;
                step_out    <= '0;
                point_idx   <= '0;
                settle_cnt  <= '0;
                busy        <= 1'b1;
                state       <= S_SETTLE;
              end
            end
          end
          S_SETTLE: begin
            step_out <= '0;
            if (settle_cnt == 16'(SETTLE - 1)) begin
              state    <= S_DWELL;
              step_out <= step_l;
              sync     <= 1'b1;
              clk_cnt  <= '0;
              tick_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 16'd1;
            end
          end
          // N clocks per tick, ticks_total ticks per point.
          S_DWELL: begin
            if (clk_cnt == N_out - 32'd1) begin
              clk_cnt <= '0;
              if (tick_cnt == ticks_total - 32'd1) begin
                state    <= S_ADV;
                step_out <= '0;
              end else begin
                tick_cnt <= tick_cnt + 32'd1;
              end
            end else begin
              clk_cnt <= clk_cnt + 32'd1;
            end
          end
          S_ADV: begin
            settle_cnt <= '0;
            step_out   <= '0;
            if (last_c) begin
              done <= 1'b1;
`ifdef DAC_SCAN_LOOP_EN
              offset_out <= start_l;
              point_idx  <= '0;
              state      <= S_SETTLE;
`else
              state      <= S_DONE;
`endif
            end else begin
              offset_out <= nxt_c[15:0];
              point_idx  <= point_idx + 16'd1;
              state      <= S_SETTLE;
            end
          end
          S_DONE: begin
            step_out <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_carry_scan.sv
// Self-checking bench for dac_carry_scan: vector table of sweeps plus abort, busy-start and async-reset sequences.
module tb_dac_carry_scan;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [31:0]        N_in = 32'd1;
  logic signed [15:0] step_in = '0;
  logic signed [15:0] off_start = '0;
  logic signed [15:0] off_stop = '0;
  logic signed [15:0] off_inc = '0;
  logic [7:0]         reps = '0;
  logic [31:0]        N_out;
  logic signed [15:0] step_out;
  logic signed [15:0] offset_out;
  logic               busy, done, err, sync;
  logic [15:0]        point_idx;

  dac_carry_scan dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .N_in(N_in),
    .step_in(step_in), .off_start(off_start), .off_stop(off_stop), .off_inc(off_inc),
    .reps(reps), .N_out(N_out), .step_out(step_out), .offset_out(offset_out),
    .busy(busy), .done(done), .err(err), .sync(sync), .point_idx(point_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int stp; int os; int stop; int inc; int reps;
    int pts; int dwell; bit rej;
  } vec_t;

  typedef struct { int off; int idx; } pt_t;

  pt_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  done_cnt = 0;
  int  sync_cnt = 0;
  int  exp_dwell = 0;
  int  cur_step = 0;
  int  run = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected point on each sync and measures every dwell run length.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (sync) begin
        sync_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_sync", 1, 0);
        end else begin
          pt_t p;
          p = q.pop_front();
          chk("point_offset", int'($signed(offset_out)), p.off);
          chk("point_idx", int'(point_idx), p.idx);
          chk("dwell_step", int'($signed(step_out)), cur_step);
        end
      end
      if (step_out != 16'sd0) begin
        run++;
      end else begin
        if (run > 0 && busy) chk("dwell_len", run, exp_dwell);
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  task automatic drive_start(input vec_t v);
    @(negedge clk);
    N_in = 32'(v.n); step_in = 16'(v.stp); off_start = 16'(v.os);
    off_stop = 16'(v.stop); off_inc = 16'(v.inc); reps = 8'(v.reps);
    cur_step = v.stp; exp_dwell = v.dwell;
    done_cnt = 0; sync_cnt = 0;
    if (!v.rej)
      for (int k = 0; k < v.pts; k++) q.push_back('{off: v.os + k * v.inc, idx: k});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    bit dseen;
    drive_start(v);
    if (v.rej) begin
      chk("err_pulse", int'(err), 1);
      chk("err_busy", int'(busy), 0);
      @(negedge clk);
      chk("err_one_cycle", int'(err), 0);
      chk("err_no_done", done_cnt, 0);
      return;
    end
    chk("start_busy", int'(busy), 1);
    chk("start_offset", int'($signed(offset_out)), v.os);
    chk("start_nout", longint'(N_out), v.n);
    cnt = 0;
    while (step_out == 16'sd0 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    chk("settle_len", cnt, 16);
    cnt = 0;
    dseen = 1'b0;
    while (busy && cnt < 30000) begin
      dseen = done;
      @(negedge clk);
      cnt++;
    end
    chk("sweep_timeout", int'(busy), 0);
    chk("done_before_idle", int'(dseen), 1);
    chk("done_count", done_cnt, 1);
    chk("sync_count", sync_cnt, v.pts);
    chk("points_left", q.size(), 0);
    chk("final_offset", int'($signed(offset_out)), v.os + (v.pts - 1) * v.inc);
    chk("final_step", int'($signed(step_out)), 0);
  endtask

  vec_t vecs[8];
  vec_t basic;

  initial begin
    int cnt;
    basic   = '{n: 2, stp: 100, os: 0, stop: 3, inc: 1, reps: 1, pts: 4, dwell: 120, rej: 0};
    vecs[0] = basic;
    vecs[1] = '{n: 1, stp: 5, os: 32760, stop: 32767, inc: 4, reps: 1, pts: 2, dwell: 60, rej: 0};
    vecs[2] = '{n: 1, stp: -7, os: 0, stop: -8, inc: -4, reps: 1, pts: 3, dwell: 60, rej: 0};
    vecs[3] = '{n: 1, stp: 9, os: 0, stop: -8, inc: 4, reps: 1, pts: 1, dwell: 60, rej: 0};
    vecs[4] = '{n: 2, stp: 3, os: 5, stop: 5, inc: 1, reps: 0, pts: 1, dwell: 120, rej: 0};
    vecs[5] = '{n: 0, stp: 3, os: 0, stop: 3, inc: 1, reps: 1, pts: 0, dwell: 0, rej: 1};
    vecs[6] = '{n: 1, stp: 11, os: 10, stop: 20, inc: 0, reps: 1, pts: 1, dwell: 60, rej: 0};
    vecs[7] = '{n: 1, stp: -1, os: -3, stop: -2, inc: 1, reps: 2, pts: 2, dwell: 120, rej: 0};

    #12;
    chk("rst_nout", longint'(N_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'($signed(step_out)), 0);
    chk("rst_idx", int'(point_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start together with abort in IDLE must be ignored.
    @(negedge clk);
    abort = 1'b1; start = 1'b1; N_in = 32'd2;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_err", int'(err), 0);

    // Abort during the third point, with an ignored start while busy beforehand.
    drive_start(basic);
    cnt = 0;
    while (sync_cnt < 1 && cnt < 2000) begin @(negedge clk); cnt++; end
    N_in = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_err", int'(err), 0);
    chk("busy_start_busy", int'(busy), 1);
    cnt = 0;
    while (sync_cnt < 3 && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("abort_reach_pt2", sync_cnt, 3);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_step", int'($signed(step_out)), 0);
    chk("abort_offset", int'($signed(offset_out)), 2);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    q.delete();
    run_vec(basic);

    // Async reset in the settle window of the second point.
    drive_start(basic);
    cnt = 0;
    while (!(point_idx == 16'd1 && step_out == 16'sd0) && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("reset_reach_pt1", int'(point_idx), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_offset", int'($signed(offset_out)), 0);
    chk("arst_idx", int'(point_idx), 0);
    chk("arst_nout", longint'(N_out), 1);
    chk("arst_step", int'($signed(step_out)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    run_vec(vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
